// File: rtl/dpram_pkg.sv
// Shared types, constants and helpers for the dual-port arbitrated RAM.
// Helper functions work on a fixed maximum width; callers zero-extend
// their operands and truncate the result back to DATA_W.
package dpram_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int BYTE_W     = 8;
    localparam int COLL_CNT_W = 16;
    localparam logic [COLL_CNT_W-1:0] COLL_SAT = 16'hFFFF;

    // Widest word the helpers handle; DATA_W must not exceed this.
    localparam int MAX_W  = 1024;
    localparam int MAX_BE = MAX_W / BYTE_W;

    // Replace the lanes of old_w selected by be with the lanes of new_w.
    function automatic logic [MAX_W-1:0] lane_merge(
        input logic [MAX_W-1:0]  old_w,
        input logic [MAX_W-1:0]  new_w,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_BE; i++) begin
            if (be[i]) begin
                res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

    // Even-parity bit: data plus this bit always holds an even number of ones.
    function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dpram_port_ctrl.sv
// Per-port front end: range check, access qualification, registered read
// data with rvalid/err pulses. Build option DPRAM_PARITY_EN adds a parity
// check on the word being read and a perr_o pulse alongside rvalid_o.
module dpram_port_ctrl
    import dpram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     run_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        addr_i,
    // Word as it will read after this cycle's committed writes.
    input  logic [DATA_W-1:0]        fwd_word_i,
`ifdef DPRAM_PARITY_EN
    input  logic [DATA_W/BYTE_W-1:0] fwd_par_i,
    output logic                     perr_o,
`endif
    output logic [IDX_W-1:0]         idx_o,
    output logic                     wr_en_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     rvalid_o,
    output logic                     err_o
);

    logic              in_range;
    logic              rd_en;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;

    // Qualify the request against run state and the legal word range.
    always_comb begin
        in_range = (addr_i < ADDR_W'(DEPTH));
        idx_o    = addr_i[IDX_W-1:0];
        wr_en_o  = run_i & req_i & we_i & in_range;
        rd_en    = run_i & req_i & ~we_i & in_range;
        rvalid_d = rd_en;
        err_d    = run_i & req_i & ~in_range;
        rdata_d  = rd_en ? fwd_word_i : rdata_q;
    end

    // Read data holds between reads; rvalid/err are single-cycle pulses.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;

`ifdef DPRAM_PARITY_EN
    logic perr_q, perr_d;

    // Flag a read whose stored parity disagrees with any lane of the word.
    always_comb begin
        perr_d = 1'b0;
        for (int i = 0; i < DATA_W/BYTE_W; i++) begin
            if (byte_parity(fwd_word_i[i*BYTE_W +: BYTE_W]) != fwd_par_i[i]) begin
                perr_d = rd_en;
            end
        end
    end

    // Parity error pulse aligned with rvalid.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr_o = perr_q;
`endif

endmodule

// File: rtl/dpram_arb.sv
// True dual-port word RAM with byte enables, write-first reads, same-address
// write arbitration (PRIO_A picks the winner), a saturating collision counter
// and a power-up clear sequence. Optional build macro DPRAM_PARITY_EN adds
// per-byte even parity storage and a_perr_o/b_perr_o outputs.
module dpram_arb
    import dpram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32,
    parameter int PRIO_A = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     ready_o,

    input  logic                     a_req_i,
    input  logic                     a_we_i,
    input  logic [ADDR_W-1:0]        a_addr_i,
    input  logic [DATA_W-1:0]        a_wdata_i,
    input  logic [DATA_W/8-1:0]      a_be_i,
    output logic [DATA_W-1:0]        a_rdata_o,
    output logic                     a_rvalid_o,
    output logic                     a_err_o,
`ifdef DPRAM_PARITY_EN
    output logic                     a_perr_o,
    output logic                     b_perr_o,
`endif
    input  logic                     b_req_i,
    input  logic                     b_we_i,
    input  logic [ADDR_W-1:0]        b_addr_i,
    input  logic [DATA_W-1:0]        b_wdata_i,
    input  logic [DATA_W/8-1:0]      b_be_i,
    output logic [DATA_W-1:0]        b_rdata_o,
    output logic                     b_rvalid_o,
    output logic                     b_err_o,

    output logic [COLL_CNT_W-1:0]    coll_cnt_o
);

    localparam int   IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int   NB     = DATA_W / BYTE_W;
    localparam logic A_WINS = (PRIO_A != 0);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        init_ptr_q, init_ptr_d;
    logic [COLL_CNT_W-1:0]   coll_cnt_q, coll_cnt_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic                    run;
    logic [IDX_W-1:0]        a_idx, b_idx;
    logic                    a_wr_en, b_wr_en;
    logic                    coll, a_commit, b_commit;
    logic [DATA_W-1:0]       a_new, b_new;
    logic [DATA_W-1:0]       a_fwd, b_fwd;

    assign run     = (state_q == ST_RUN);
    assign ready_o = run;

    // Clear sequencer: walk init_ptr over every word, then open for traffic.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            ST_INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d    = ST_RUN;
                    init_ptr_d = '0;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // State register; reset always restarts the clear from word 0.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // Arbitrate same-address writes and build the merged words to commit.
    always_comb begin
        coll     = a_wr_en & b_wr_en & (a_idx == b_idx);
        a_commit = a_wr_en & ~(coll & ~A_WINS);
        b_commit = b_wr_en & ~(coll & A_WINS);
        a_new    = DATA_W'(lane_merge(MAX_W'(mem_q[a_idx]), MAX_W'(a_wdata_i), MAX_BE'(a_be_i)));
        b_new    = DATA_W'(lane_merge(MAX_W'(mem_q[b_idx]), MAX_W'(b_wdata_i), MAX_BE'(b_be_i)));
        // A port that reads cannot write, so only the other port can forward.
        a_fwd    = (b_commit && (b_idx == a_idx)) ? b_new : mem_q[a_idx];
        b_fwd    = (a_commit && (a_idx == b_idx)) ? a_new : mem_q[b_idx];
    end

    // Saturating collision counter.
    always_comb begin
        coll_cnt_d = coll_cnt_q;
        if (coll && (coll_cnt_q != COLL_SAT)) begin
            coll_cnt_d = coll_cnt_q + 1'b1;
        end
    end

    // Collision counter register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            coll_cnt_q <= '0;
        end else begin
            coll_cnt_q <= coll_cnt_d;
        end
    end

    assign coll_cnt_o = coll_cnt_q;

    // Storage array; the arbiter guarantees the two commits never share a word.
    always_ff @(posedge clk_i) begin
        if (!run) begin
            mem_q[init_ptr_q] <= '0;
        end else begin
            if (a_commit) mem_q[a_idx] <= a_new;
            if (b_commit) mem_q[b_idx] <= b_new;
        end
    end

`ifdef DPRAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] a_par_new, b_par_new;
    logic [NB-1:0] a_par_fwd, b_par_fwd;

    // Parity follows the lanes actually written; untouched lanes keep theirs.
    always_comb begin
        a_par_new = par_q[a_idx];
        b_par_new = par_q[b_idx];
        for (int i = 0; i < NB; i++) begin
            if (a_be_i[i]) a_par_new[i] = byte_parity(a_wdata_i[i*BYTE_W +: BYTE_W]);
            if (b_be_i[i]) b_par_new[i] = byte_parity(b_wdata_i[i*BYTE_W +: BYTE_W]);
        end
        a_par_fwd = (b_commit && (b_idx == a_idx)) ? b_par_new : par_q[a_idx];
        b_par_fwd = (a_commit && (a_idx == b_idx)) ? a_par_new : par_q[b_idx];
    end

    // Parity storage, cleared alongside the data during init.
    always_ff @(posedge clk_i) begin
        if (!run) begin
            par_q[init_ptr_q] <= '0;
        end else begin
            if (a_commit) par_q[a_idx] <= a_par_new;
            if (b_commit) par_q[b_idx] <= b_par_new;
        end
    end
`endif

    dpram_port_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_port_a (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .run_i      (run),
        .req_i      (a_req_i),
        .we_i       (a_we_i),
        .addr_i     (a_addr_i),
        .fwd_word_i (a_fwd),
`ifdef DPRAM_PARITY_EN
        .fwd_par_i  (a_par_fwd),
        .perr_o     (a_perr_o),
`endif
        .idx_o      (a_idx),
        .wr_en_o    (a_wr_en),
        .rdata_o    (a_rdata_o),
        .rvalid_o   (a_rvalid_o),
        .err_o      (a_err_o)
    );

    dpram_port_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_port_b (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .run_i      (run),
        .req_i      (b_req_i),
        .we_i       (b_we_i),
        .addr_i     (b_addr_i),
        .fwd_word_i (b_fwd),
`ifdef DPRAM_PARITY_EN
        .fwd_par_i  (b_par_fwd),
        .perr_o     (b_perr_o),
`endif
        .idx_o      (b_idx),
        .wr_en_o    (b_wr_en),
        .rdata_o    (b_rdata_o),
        .rvalid_o   (b_rvalid_o),
        .err_o      (b_err_o)
    );

endmodule

// File: tb/tb_dpram_arb.sv
// Directed bench for dpram_arb. Two instances share all stimulus: dut1 with
// port A priority, dut0 with port B priority, so collision outcomes of both
// settings are checked from the same vectors.
module tb_dpram_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [3:0]  a_be, b_be;

    logic        p1_ready, p1_a_rvalid, p1_a_err, p1_b_rvalid, p1_b_err;
    logic [31:0] p1_a_rdata, p1_b_rdata;
    logic [15:0] p1_coll;
    logic        p0_ready, p0_a_rvalid, p0_a_err, p0_b_rvalid, p0_b_err;
    logic [31:0] p0_a_rdata, p0_b_rdata;
    logic [15:0] p0_coll;
`ifdef DPRAM_PARITY_EN
    logic        p1_a_perr, p1_b_perr, p0_a_perr, p0_b_perr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dpram_arb #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .PRIO_A(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .ready_o(p1_ready),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_be_i(a_be),
        .a_rdata_o(p1_a_rdata), .a_rvalid_o(p1_a_rvalid), .a_err_o(p1_a_err),
`ifdef DPRAM_PARITY_EN
        .a_perr_o(p1_a_perr), .b_perr_o(p1_b_perr),
`endif
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_be_i(b_be),
        .b_rdata_o(p1_b_rdata), .b_rvalid_o(p1_b_rvalid), .b_err_o(p1_b_err),
        .coll_cnt_o(p1_coll)
    );

    dpram_arb #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .PRIO_A(0)) dut0 (
        .clk_i(clk), .reset_i(reset), .ready_o(p0_ready),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_be_i(a_be),
        .a_rdata_o(p0_a_rdata), .a_rvalid_o(p0_a_rvalid), .a_err_o(p0_a_err),
`ifdef DPRAM_PARITY_EN
        .a_perr_o(p0_a_perr), .b_perr_o(p0_b_perr),
`endif
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_be_i(b_be),
        .b_rdata_o(p0_b_rdata), .b_rvalid_o(p0_b_rvalid), .b_err_o(p0_b_err),
        .coll_cnt_o(p0_coll)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
    endtask

    task automatic drv_b(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
    endtask

    task automatic idle();
        drv_a(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        drv_b(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    endtask

    // Read one word through port A of both instances.
    task automatic rd_a(input logic [31:0] addr);
        drv_a(1'b1, 1'b0, addr, 32'd0, 4'h0);
        drv_b(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] acc;
        int          vcnt;

        reset = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_ready",  {31'd0, p1_ready}, 32'd0);
        chk("rst_rdata",  p1_a_rdata, 32'd0);
        chk("rst_rvalid", {31'd0, p1_a_rvalid}, 32'd0);
        chk("rst_err",    {31'd0, p1_a_err}, 32'd0);
        chk("rst_coll",   {16'd0, p1_coll}, 32'd0);

        // Clear sequence length after release.
        reset = 1'b0;
        n = 0;
        while (!p1_ready && n < 200) begin
            tick();
            n++;
        end
        chk("init_len",    32'(n), 32'd64);
        chk("init_len_p0", {31'd0, p0_ready}, 32'd1);

        // Every word reads back zero on both ports.
        acc  = '0;
        vcnt = 0;
        for (int i = 0; i < 64; i++) begin
            drv_a(1'b1, 1'b0, 32'(i), 32'd0, 4'h0);
            drv_b(1'b1, 1'b0, 32'(63 - i), 32'd0, 4'h0);
            tick();
            acc  = acc | p1_a_rdata | p1_b_rdata;
            vcnt = vcnt + int'(p1_a_rvalid) + int'(p1_b_rvalid);
        end
        chk("init_zero",   acc, 32'd0);
        chk("init_rvalid", 32'(vcnt), 32'd128);

        // Full-word write then read back.
        drv_a(1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF);
        drv_b(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        tick();
        chk("wr_no_rvalid", {31'd0, p1_a_rvalid}, 32'd0);
        rd_a(32'd5);
        chk("rd5_rvalid", {31'd0, p1_a_rvalid}, 32'd1);
        chk("rd5_data",   p1_a_rdata, 32'hDEADBEEF);
        idle();
        tick();
        chk("rvalid_pulse", {31'd0, p1_a_rvalid}, 32'd0);
        chk("rdata_hold",   p1_a_rdata, 32'hDEADBEEF);

        // Partial byte enables.
        drv_a(1'b1, 1'b1, 32'd6, 32'h12345678, 4'b0101);
        tick();
        rd_a(32'd6);
        chk("be_merge", p1_a_rdata, 32'h00340078);

        // be=0 is a legal no-op.
        drv_a(1'b1, 1'b1, 32'd5, 32'hFFFFFFFF, 4'h0);
        tick();
        chk("be0_err", {31'd0, p1_a_err}, 32'd0);
        rd_a(32'd5);
        chk("be0_nochange", p1_a_rdata, 32'hDEADBEEF);

        // Same-address write collision.
        drv_a(1'b1, 1'b1, 32'd3, 32'h11111111, 4'hF);
        drv_b(1'b1, 1'b1, 32'd3, 32'h22222222, 4'h3);
        tick();
        chk("coll_cnt_p1", {16'd0, p1_coll}, 32'd1);
        chk("coll_cnt_p0", {16'd0, p0_coll}, 32'd1);
        chk("coll_b_err",  {31'd0, p1_b_err}, 32'd0);
        chk("coll_a_err",  {31'd0, p0_a_err}, 32'd0);
        rd_a(32'd3);
        chk("coll_prio_a", p1_a_rdata, 32'h11111111);
        chk("coll_prio_b", p0_a_rdata, 32'h00002222);

        // Write-first: B reads the word A writes in the same cycle.
        drv_a(1'b1, 1'b1, 32'd9, 32'hA5A5A5A5, 4'hF);
        drv_b(1'b1, 1'b0, 32'd9, 32'd0, 4'h0);
        tick();
        chk("wf_b_data",   p1_b_rdata, 32'hA5A5A5A5);
        chk("wf_b_data0",  p0_b_rdata, 32'hA5A5A5A5);
        chk("wf_b_rvalid", {31'd0, p1_b_rvalid}, 32'd1);
        chk("wf_no_coll",  {16'd0, p1_coll}, 32'd1);

        // Write-first with partial lanes returns the merged word.
        drv_a(1'b1, 1'b1, 32'd12, 32'hAABBCCDD, 4'b1100);
        drv_b(1'b1, 1'b0, 32'd12, 32'd0, 4'h0);
        tick();
        chk("wf_merge", p1_b_rdata, 32'hAABB0000);

        // Out-of-range write: error pulse, no aliasing into word 0.
        drv_a(1'b1, 1'b1, 32'd64, 32'hFFFFFFFF, 4'hF);
        drv_b(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        tick();
        chk("oor_wr_err",    {31'd0, p1_a_err}, 32'd1);
        chk("oor_wr_rvalid", {31'd0, p1_a_rvalid}, 32'd0);
        idle();
        tick();
        chk("oor_err_pulse", {31'd0, p1_a_err}, 32'd0);
        rd_a(32'd0);
        chk("oor_nowrite", p1_a_rdata, 32'd0);

        // Out-of-range read: err, no rvalid, rdata holds.
        rd_a(32'd5);
        rd_a(32'd200);
        chk("oor_rd_err",    {31'd0, p1_a_err}, 32'd1);
        chk("oor_rd_rvalid", {31'd0, p1_a_rvalid}, 32'd0);
        chk("oor_rd_hold",   p1_a_rdata, 32'hDEADBEEF);

        // Reset partway through the clear; requests during init are ignored.
        reset = 1'b1;
        idle();
        tick();
        tick();
        chk("rst2_coll", {16'd0, p1_coll}, 32'd0);
        reset = 1'b0;
        acc = '0;
        drv_b(1'b1, 1'b0, 32'd200, 32'd0, 4'h0);
        for (int i = 0; i < 30; i++) begin
            tick();
            acc = acc | {30'd0, p1_b_err, p1_b_rvalid};
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        drv_a(1'b1, 1'b1, 32'd2, 32'hCAFEF00D, 4'hF);
        n = 0;
        while (!p1_ready && n < 200) begin
            tick();
            acc = acc | {30'd0, p1_b_err, p1_b_rvalid};
            n++;
        end
        chk("reinit_len", 32'(n), 32'd64);
        chk("init_ignore_flags", acc, 32'd0);
        rd_a(32'd2);
        chk("init_ignore_wr", p1_a_rdata, 32'd0);
        rd_a(32'd5);
        chk("reinit_clear", p1_a_rdata, 32'd0);

`ifdef DPRAM_PARITY_EN
        // Parity: clean read, then a single stored bit flipped.
        drv_a(1'b1, 1'b1, 32'd7, 32'h0F0F0F0F, 4'hF);
        tick();
        rd_a(32'd7);
        chk("par_clean", {30'd0, p1_a_rvalid, p1_a_perr}, 32'd2);
        idle();
        tick();
        dut1.mem_q[7][0] = ~dut1.mem_q[7][0];
        rd_a(32'd7);
        chk("par_flip", {30'd0, p1_a_rvalid, p1_a_perr}, 32'd3);
`endif

        idle();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
